// File: rtl/cpstr_man_rx.sv
// cpstr_man_rx: receive-side stream demultiplexer.
// Splits one escaped byte stream into NUM_STREAMS byte streams.
// Escape pairs {ESC_CHAR, idx} select the destination stream.
// The pair {ESC_CHAR, ESC_CHAR} carries a literal ESC_CHAR data byte.
// A single output register holds one byte, so bytes leave in arrival order.
module cpstr_man_rx #(
  parameter int unsigned NUM_STREAMS = 2,
  parameter logic [7:0]  ESC_CHAR    = 8'hA5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [8*NUM_STREAMS-1:0]   o_data,
  output logic [NUM_STREAMS-1:0]     o_valid,
  input  logic [NUM_STREAMS-1:0]     i_ready,
  output logic [7:0]                 o_stridx,
  output logic                       o_stridx_valid,
  output logic                       o_err,
  output logic                       o_drop
);

  typedef enum logic [0:0] {StData, StEsc} state_e;

  // Stream count as a byte, so a received index compares at full 8-bit width.
  localparam logic [7:0] NumStreamsB = 8'(NUM_STREAMS);

  state_e     state_q;
  logic       full_q;
  logic [7:0] data_q;
  logic [7:0] idx_q;
  logic [7:0] stridx_q;
  logic       stridx_valid_q;
  logic       err_q;
  logic       drop_q;

  logic [NUM_STREAMS-1:0] valid;
  logic                   drain;
  logic                   accept;
  logic                   is_data;
  logic                   is_sel;
  logic                   is_bad;

  // Lane decode, drain/accept handshake and classification of the accepted byte.
  always_comb begin
    valid = '0;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      valid[k] = full_q && (idx_q == 8'(k));
    end
    drain   = |(valid & i_ready);
    // Control bytes also wait for the register, which keeps ordering strict.
    o_ready = !full_q || drain;
    accept  = i_valid && o_ready;

    is_data = 1'b0;
    is_sel  = 1'b0;
    is_bad  = 1'b0;
    if (accept) begin
      unique case (state_q)
        StData: is_data = (i_data != ESC_CHAR);
        StEsc: begin
          if (i_data == ESC_CHAR) begin
            is_data = 1'b1;
          end else if (i_data < NumStreamsB) begin
            is_sel = 1'b1;
          end else begin
            is_bad = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Parser FSM, current selection, output register and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StData;
      full_q         <= 1'b0;
      data_q         <= 8'h00;
      idx_q          <= 8'h00;
      stridx_q       <= 8'h00;
      stridx_valid_q <= 1'b0;
      err_q          <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      if (accept) begin
        unique case (state_q)
          StData:  state_q <= (i_data == ESC_CHAR) ? StEsc : StData;
          StEsc:   state_q <= StData;
          default: state_q <= StData;
        endcase
      end

      if (drain) begin
        full_q <= 1'b0;
      end

      // A load in the same cycle as a drain overrides the clear above.
      drop_q <= 1'b0;
      if (is_data) begin
        if (stridx_valid_q) begin
          full_q <= 1'b1;
          data_q <= i_data;
          idx_q  <= stridx_q;
        end else begin
          drop_q <= 1'b1;
        end
      end

      // The new selection only affects later bytes; a held byte keeps idx_q.
      if (is_sel) begin
        stridx_q       <= i_data;
        stridx_valid_q <= 1'b1;
      end

      err_q <= is_bad;
    end
  end

  assign o_valid        = valid;
  assign o_data         = {NUM_STREAMS{data_q}};
  assign o_stridx       = stridx_q;
  assign o_stridx_valid = stridx_valid_q;
  assign o_err          = err_q;
  assign o_drop         = drop_q;

endmodule

// File: tb/tb_cpstr_man_rx.sv
// Directed bench for cpstr_man_rx with NUM_STREAMS = 2 and ESC_CHAR = 0xA5.
module tb_cpstr_man_rx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_valid;
  logic [1:0]  i_ready;
  logic [7:0]  o_stridx;
  logic        o_stridx_valid;
  logic        o_err;
  logic        o_drop;

  int n_checks = 0;
  int n_fail   = 0;

  cpstr_man_rx #(
    .NUM_STREAMS(2),
    .ESC_CHAR   (8'hA5)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_stridx      (o_stridx),
    .o_stridx_valid(o_stridx_valid),
    .o_err         (o_err),
    .o_drop        (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_data  = 8'h00;
    i_valid = 1'b0;
    i_ready = 2'b11;
    #3;
    check("rst_valid", {14'd0, o_valid}, 16'h0000);
    check("rst_data", o_data, 16'h0000);
    check("rst_stridx", {8'd0, o_stridx}, 16'h0000);
    check("rst_stridx_valid", {15'd0, o_stridx_valid}, 16'h0000);
    check("rst_err", {15'd0, o_err}, 16'h0000);
    check("rst_drop", {15'd0, o_drop}, 16'h0000);
    check("rst_ready", {15'd0, o_ready}, 16'h0001);
    #4 rst_n = 1'b1;
    tick();

    // Drop before select.
    send(8'h11);
    check("t1_drop_pulse", {15'd0, o_drop}, 16'h0001);
    check("t1_drop_novalid", {14'd0, o_valid}, 16'h0000);
    send(8'hA5);
    check("t1_drop_oneshot", {15'd0, o_drop}, 16'h0000);
    send(8'h01);
    check("t1_stridx", {8'd0, o_stridx}, 16'h0001);
    check("t1_stridx_valid", {15'd0, o_stridx_valid}, 16'h0001);
    check("t1_sel_noout", {14'd0, o_valid}, 16'h0000);
    send(8'h22);
    check("t1_v22", {14'd0, o_valid}, 16'h0002);
    check("t1_d22", {8'd0, o_data[15:8]}, 16'h0022);
    send(8'h33);
    check("t1_v33", {14'd0, o_valid}, 16'h0002);
    check("t1_d33", {8'd0, o_data[15:8]}, 16'h0033);
    check("t1_nodrop", {15'd0, o_drop}, 16'h0000);
    tick();
    check("t1_drained", {14'd0, o_valid}, 16'h0000);

    // Literal escape.
    send(8'hA5);
    send(8'h00);
    check("t2_stridx0", {8'd0, o_stridx}, 16'h0000);
    send(8'hA5);
    check("t2_esc_noout", {14'd0, o_valid}, 16'h0000);
    send(8'hA5);
    check("t2_vA5", {14'd0, o_valid}, 16'h0001);
    check("t2_dA5", {8'd0, o_data[7:0]}, 16'h00A5);
    check("t2_noerr", {15'd0, o_err}, 16'h0000);
    send(8'h00);
    check("t2_v00", {14'd0, o_valid}, 16'h0001);
    check("t2_d00", {8'd0, o_data[7:0]}, 16'h0000);
    tick();

    // Bad escape.
    send(8'hA5);
    send(8'h01);
    send(8'hA5);
    send(8'h07);
    check("t3_err_pulse", {15'd0, o_err}, 16'h0001);
    check("t3_stridx_kept", {8'd0, o_stridx}, 16'h0001);
    check("t3_err_noout", {14'd0, o_valid}, 16'h0000);
    send(8'h44);
    check("t3_err_oneshot", {15'd0, o_err}, 16'h0000);
    check("t3_v44", {14'd0, o_valid}, 16'h0002);
    check("t3_d44", {8'd0, o_data[15:8]}, 16'h0044);
    tick();

    // Backpressure during a selection change.
    send(8'hA5);
    send(8'h00);
    i_ready = 2'b00;
    send(8'h55);
    check("t4_v55", {14'd0, o_valid}, 16'h0001);
    check("t4_d55", {8'd0, o_data[7:0]}, 16'h0055);
    i_valid = 1'b1;
    i_data  = 8'hA5;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_ready", {15'd0, o_ready}, 16'h0000);
      check("t4_stall_valid", {14'd0, o_valid}, 16'h0001);
      check("t4_stall_data", {8'd0, o_data[7:0]}, 16'h0055);
      tick();
    end
    i_ready = 2'b01;
    #1;
    check("t4_ready_rise", {15'd0, o_ready}, 16'h0001);
    tick();
    i_valid = 1'b0;
    check("t4_after_drain", {14'd0, o_valid}, 16'h0000);
    send(8'h01);
    check("t4_stridx1", {8'd0, o_stridx}, 16'h0001);
    send(8'h66);
    check("t4_v66", {14'd0, o_valid}, 16'h0002);
    check("t4_d66", {8'd0, o_data[15:8]}, 16'h0066);
    check("t4_onehot", {14'd0, o_valid & (o_valid - 2'd1)}, 16'h0000);
    i_ready = 2'b11;
    tick();
    check("t4_drained", {14'd0, o_valid}, 16'h0000);

    // Split escape pair.
    send(8'hA5);
    send(8'h00);
    check("t5_pre_stridx", {8'd0, o_stridx}, 16'h0000);
    send(8'hA5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_idle_noout", {14'd0, o_valid}, 16'h0000);
    end
    send(8'h01);
    check("t5_stridx", {8'd0, o_stridx}, 16'h0001);
    check("t5_noout", {14'd0, o_valid}, 16'h0000);

    // Reset with a held byte and a pending input.
    i_ready = 2'b00;
    send(8'h77);
    check("t6_full", {14'd0, o_valid}, 16'h0002);
    i_valid = 1'b1;
    i_data  = 8'hA5;
    rst_n   = 1'b0;
    #1;
    check("t6_rst_valid", {14'd0, o_valid}, 16'h0000);
    check("t6_rst_data", o_data, 16'h0000);
    check("t6_rst_stridx", {8'd0, o_stridx}, 16'h0000);
    check("t6_rst_stridx_valid", {15'd0, o_stridx_valid}, 16'h0000);
    i_valid = 1'b0;
    i_ready = 2'b11;
    #1 rst_n = 1'b1;
    send(8'h09);
    check("t6_drop_after_rst", {15'd0, o_drop}, 16'h0001);

    // Reset abandons a pending escape; the next 0x01 is data, not a select.
    send(8'hA5);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    send(8'h01);
    check("t6_esc_abandon_drop", {15'd0, o_drop}, 16'h0001);
    check("t6_esc_abandon_nosel", {15'd0, o_stridx_valid}, 16'h0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
